// File: rtl/gaussian_pkg.sv
// Shared definitions for the gaussian window generator and core: pixel width,
// window side and the packed-window layout used by both sides of the interface.
package gaussian_pkg;

    localparam int BITS     = 8;
    localparam int WIDTH    = 7;
    localparam int WIN_BITS = WIDTH * WIDTH * BITS;

    // LSB of element A[i][j]; A[0][0] sits in the top byte, A[WIDTH-1][WIDTH-1] in the bottom byte.
    function automatic int win_lsb(input int i, input int j, input int bits, input int width);
        return bits * (width * width - 1 - (width * i + j));
    endfunction

endpackage

// File: rtl/gaussian_window_gen_line_buffer.sv
// One image line of pixel storage: a single shared address per cycle,
// the old contents are read out while the new pixel is written.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int BITS  = 8
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [BITS-1:0]          wdata_i,
    output logic [BITS-1:0]          rdata_o
);

    logic [BITS-1:0] mem_q [0:DEPTH-1];

    assign rdata_o = mem_q[addr_i];

    // Storage write; contents are never reset, the frame counters mask stale data.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/gaussian_window_gen.sv
// Streaming 7x7 window generator: six line buffers plus a register window,
// emitting one packed window per pixel whose full neighbourhood is inside the image.
module gaussian_window_gen
    import gaussian_pkg::win_lsb;
#(
    parameter int BITS  = gaussian_pkg::BITS,
    parameter int WIDTH = gaussian_pkg::WIDTH,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BITS-1:0]                in_pixel,
    input  logic                           in_sof,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH*WIDTH*BITS-1:0]    out_window,
    output logic [$clog2(IMG_H)-1:0]       out_row,
    output logic [$clog2(IMG_W)-1:0]       out_col,
    output logic                           out_last
);

    localparam int WIN_BITS = WIDTH * WIDTH * BITS;
    localparam int RW       = $clog2(IMG_H);
    localparam int CW       = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_HALF = RW'(WIDTH / 2);
    localparam logic [CW-1:0] COL_HALF = CW'(WIDTH / 2);

    logic                acc_s;
    logic                emit_s;
    logic [RW-1:0]       row_q, row_d, row_eff_s;
    logic [CW-1:0]       col_q, col_d, col_eff_s;
    logic [BITS-1:0]     lb_rd_s   [1:WIDTH-1];
    logic [BITS-1:0]     lb_wr_s   [1:WIDTH-1];
    logic [BITS-1:0]     col_vec_s [0:WIDTH-1];
    logic [BITS-1:0]     win_q     [0:WIDTH-1][0:WIDTH-1];
    logic [BITS-1:0]     win_d     [0:WIDTH-1][0:WIDTH-1];
    logic [WIN_BITS-1:0] win_flat_s;

    logic                out_valid_q;
    logic [WIN_BITS-1:0] out_window_q;
    logic [RW-1:0]       out_row_q;
    logic [CW-1:0]       out_col_q;
    logic                out_last_q;

    assign in_ready   = !out_valid_q || out_ready;
    assign acc_s      = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;

    // Position of the incoming pixel (sof restarts the frame) and the position after it.
    always_comb begin
        row_eff_s = in_sof ? '0 : row_q;
        col_eff_s = in_sof ? '0 : col_q;
        if (col_eff_s == COL_LAST) begin
            col_d = '0;
            row_d = (row_eff_s == ROW_LAST) ? '0 : row_eff_s + RW'(1);
        end else begin
            col_d = col_eff_s + CW'(1);
            row_d = row_eff_s;
        end
        emit_s = (row_eff_s >= ROW_MIN) && (col_eff_s >= COL_MIN);
    end

    // Line buffer k holds line r-k; each one cascades into the next older line.
    for (genvar k = 1; k < WIDTH; k++) begin : g_lb
        if (k == 1) begin : g_first
            assign lb_wr_s[k] = in_pixel;
        end else begin : g_rest
            assign lb_wr_s[k] = lb_rd_s[k-1];
        end
        line_buffer #(
            .DEPTH (IMG_W),
            .BITS  (BITS)
        ) u_line_buffer (
            .clk     (clk),
            .en_i    (acc_s),
            .addr_i  (col_eff_s),
            .wdata_i (lb_wr_s[k]),
            .rdata_o (lb_rd_s[k])
        );
    end

    // New column (oldest line first), shifted window and its packed form.
    always_comb begin
        for (int i = 0; i < WIDTH - 1; i++) begin
            col_vec_s[i] = lb_rd_s[WIDTH-1-i];
        end
        col_vec_s[WIDTH-1] = in_pixel;
        win_flat_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (j < WIDTH - 1) begin
                    win_d[i][j] = win_q[i][j+1];
                end else begin
                    win_d[i][j] = col_vec_s[i];
                end
                win_flat_s[win_lsb(i, j, BITS, WIDTH) +: BITS] = win_d[i][j];
            end
        end
    end

    // Window register; unreset because invalid columns are never emitted.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            win_q <= win_d;
        end
    end

    // Frame counters and registered output stage; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            if (acc_s) begin
                row_q <= row_d;
                col_q <= col_d;
            end
            if (in_ready) begin
                out_valid_q <= acc_s && emit_s;
                if (acc_s && emit_s) begin
                    out_window_q <= win_flat_s;
                    out_row_q    <= row_eff_s - ROW_HALF;
                    out_col_q    <= col_eff_s - COL_HALF;
                    out_last_q   <= (row_eff_s == ROW_LAST) && (col_eff_s == COL_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_gaussian_window_gen.sv
// Randomised self-checking bench for gaussian_window_gen on an 8x8 image, compared
// against an image-array reference model of the expected windows.
module tb_gaussian_window_gen;

    localparam int BITS  = 8;
    localparam int WIDTH = 7;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int WB    = WIDTH * WIDTH * BITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [WB-1:0] out_window;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          out_last;

    typedef struct {
        logic [WB-1:0] win;
        int            row;
        int            col;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [WB-1:0] got_win_q[$];
    logic          got_last_q[$];
    int            img[0:IMG_H-1][0:IMG_W-1];
    int            m_r, m_c;
    int            checks, errors, n_xfer;

    always #5 clk = ~clk;

    gaussian_window_gen #(
        .BITS  (BITS),
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    task automatic check_val(input string tag, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference: store the pixel at its image position; a window is the 7x7 block ending there.
    task automatic model_accept(input int pix, input logic sof);
        int   r, c;
        exp_t e;
        r = sof ? 0 : m_r;
        c = sof ? 0 : m_c;
        img[r][c] = pix & 255;
        if (r >= 6 && c >= 6) begin
            e.win = '0;
            for (int i = 0; i < 7; i++) begin
                for (int j = 0; j < 7; j++) begin
                    e.win[WB-1-8*(7*i+j) -: 8] = 8'(img[r-6+i][c-6+j]);
                end
            end
            e.row  = r - 3;
            e.col  = c - 3;
            e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
            exp_q.push_back(e);
        end
        c++;
        if (c == IMG_W) begin
            c = 0;
            r++;
            if (r == IMG_H) r = 0;
        end
        m_r = r;
        m_c = c;
    endtask

    task automatic do_cycle(input logic v, input int pix, input logic sof, input logic ordy, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_pixel  = 8'(pix);
        in_sof    = sof;
        out_ready = ordy;
        #1;
        exp_rdy = (exp_q.size() == 0) || ordy;
        check_val("out_valid", WB'(out_valid), WB'(exp_q.size() != 0));
        check_val("in_ready", WB'(in_ready), WB'(exp_rdy));
        if (exp_q.size() != 0) begin
            check_val("window", out_window, exp_q[0].win);
            check_val("row", WB'(out_row), WB'(exp_q[0].row));
            check_val("col", WB'(out_col), WB'(exp_q[0].col));
            check_val("last", WB'(out_last), WB'(exp_q[0].last));
            if (ordy) begin
                got_win_q.push_back(out_window);
                got_last_q.push_back(out_last);
                void'(exp_q.pop_front());
                n_xfer++;
            end
        end
        acc = v && exp_rdy;
        if (acc) model_accept(pix, sof);
    endtask

    // mode 0: (base+idx)&255, 1: random, 2: constant base
    task automatic send_frame(input int base, input int npix, input logic sof_first,
                              input int mode, input logic rnd, input int stall_idx);
        logic acc, v, ordy;
        int   pix, budget;
        for (int idx = 0; idx < npix; idx++) begin
            pix = (mode == 0) ? ((base + idx) & 255) : (mode == 1) ? int'($urandom_range(0, 255)) : base;
            if (idx == stall_idx) begin
                for (int s = 0; s < 5; s++) do_cycle(1'b1, pix, sof_first && idx == 0, 1'b0, acc);
            end
            budget = 0;
            do begin
                v    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                ordy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                do_cycle(v, pix, sof_first && idx == 0, ordy, acc);
                budget++;
            end while (!acc && budget < 100);
            if (!acc) begin
                check_val("accept_timeout", WB'(0), WB'(1));
                return;
            end
        end
    endtask

    task automatic drain(input logic rnd);
        logic acc;
        int   budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            do_cycle(1'b0, 0, 1'b0, rnd ? ($urandom_range(0, 1) != 0) : 1'b1, acc);
            budget++;
        end
        do_cycle(1'b0, 0, 1'b0, 1'b1, acc);
        check_val("drain", WB'(exp_q.size()), WB'(0));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_valid", WB'(out_valid), WB'(0));
        check_val("rst_window", out_window, WB'(0));
        check_val("rst_row", WB'(out_row), WB'(0));
        check_val("rst_col", WB'(out_col), WB'(0));
        check_val("rst_last", WB'(out_last), WB'(0));
        exp_q.delete();
        m_r = 0;
        m_c = 0;
    endtask

    initial begin
        int            n0;
        logic [WB-1:0] w, ones;
        rst = 1'b1; in_valid = 1'b0; in_pixel = 8'd0; in_sof = 1'b0; out_ready = 1'b0;
        checks = 0; errors = 0; n_xfer = 0; m_r = 0; m_c = 0;
        repeat (2) @(posedge clk);
        reset_dut();

        // Full frame, pixel = 8r+c, no stalls
        got_win_q.delete(); got_last_q.delete();
        n0 = n_xfer;
        send_frame(0, 64, 1'b1, 0, 1'b0, -1);
        drain(1'b0);
        check_val("nwin_basic", WB'(n_xfer - n0), WB'(4));
        if (got_win_q.size() == 4) begin
            w = got_win_q[0];
            check_val("w0_a00", WB'(w[391 -: 8]), WB'(0));
            check_val("w0_a33", WB'(w[391-8*24 -: 8]), WB'(27));
            check_val("w0_a66", WB'(w[7:0]), WB'(54));
            w = got_win_q[1];
            check_val("w1_a00", WB'(w[391 -: 8]), WB'(1));
            check_val("w1_a66", WB'(w[7:0]), WB'(55));
            w = got_win_q[3];
            check_val("w3_a66", WB'(w[7:0]), WB'(63));
            check_val("lasts", WB'({got_last_q[0], got_last_q[1], got_last_q[2], got_last_q[3]}), WB'(4'b0001));
        end

        // Output stalled 5 cycles while the first window is pending
        n0 = n_xfer;
        send_frame(0, 64, 1'b1, 0, 1'b0, 55);
        drain(1'b0);
        check_val("nwin_stall", WB'(n_xfer - n0), WB'(4));

        // Two back-to-back frames
        n0 = n_xfer;
        send_frame(0, 64, 1'b1, 0, 1'b0, -1);
        send_frame(64, 64, 1'b1, 0, 1'b0, -1);
        drain(1'b0);
        check_val("nwin_b2b", WB'(n_xfer - n0), WB'(8));

        // sof mid-frame at pixel 30
        n0 = n_xfer;
        send_frame(0, 30, 1'b1, 0, 1'b0, -1);
        send_frame(100, 64, 1'b1, 0, 1'b0, -1);
        drain(1'b0);
        check_val("nwin_sof_mid", WB'(n_xfer - n0), WB'(4));

        // Reset while a window is pending, then a clean frame without sof
        send_frame(0, 55, 1'b1, 0, 1'b0, -1);
        reset_dut();
        n0 = n_xfer;
        send_frame(32, 64, 1'b0, 0, 1'b0, -1);
        drain(1'b0);
        check_val("nwin_after_rst", WB'(n_xfer - n0), WB'(4));

        // Constant 255 image with random handshakes
        got_win_q.delete(); got_last_q.delete();
        n0 = n_xfer;
        send_frame(255, 64, 1'b1, 2, 1'b1, -1);
        drain(1'b1);
        check_val("nwin_const", WB'(n_xfer - n0), WB'(4));
        ones = '1;
        foreach (got_win_q[k]) check_val("const_win", got_win_q[k], ones);

        // Random images and random handshakes
        n0 = n_xfer;
        for (int f = 0; f < 3; f++) send_frame(0, 64, 1'b1, 1, 1'b1, -1);
        drain(1'b1);
        check_val("nwin_rand", WB'(n_xfer - n0), WB'(12));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gaussian_window_gen.md
Name: gaussian_window_gen

Overview:
- Streaming 7x7 window generator that sits directly upstream of the combinational gaussian core.
- Accepts one raster-order pixel per handshake and keeps 6 line buffers plus a 7x7 register window.
- Emits the 392-bit packed window, with centre coordinates, for every pixel position where the full 7x7 neighbourhood lies inside the image.
- No border padding: a frame of IMG_W x IMG_H pixels yields (IMG_W-6) x (IMG_H-6) windows.

Parameters:
- BITS, 8, pixel width in bits.
- WIDTH, 7, window side; the logic is written for 7, other values are untested.
- IMG_W, 640, pixels per line (line buffer depth); must be >= WIDTH.
- IMG_H, 480, lines per frame; must be >= WIDTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel present.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pixel  in  BITS  pixel value, raster order.
- in_sof  in  1  marks the first pixel of a frame.
- out_valid  out  1  out_window and coordinates valid.
- out_ready  in  1  downstream accepts the window.
- out_window  out  WIDTH*WIDTH*BITS (392)  packed window, layout defined under Behaviour.
- out_row  out  $clog2(IMG_H)  row of the centre pixel.
- out_col  out  $clog2(IMG_W)  column of the centre pixel.
- out_last  out  1  last window of the frame (centre at row IMG_H-4, column IMG_W-4).

Behaviour:
- Reset values: out_valid=0, out_window=0, out_row=0, out_col=0, out_last=0. Internal counters: row=0, col=0. Line buffer and window registers are not reset; their contents are masked by the counters.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- On accept of a pixel at (r,c), where r and c are the counter values, or 0,0 if in_sof=1:
  - Column vector formed, oldest line first: {lb6[c], lb5[c], ..., lb1[c], in_pixel}.
  - lbk holds line r-k.
  - Line buffers updated read-before-write: lbk[c] <= lb(k-1)[c] for k=6..2, and lb1[c] <= in_pixel.
  - Window shifts one column left; the new vector becomes column 6.
  - Counters advance: c wraps at IMG_W-1 to 0 and increments r; r wraps at IMG_H-1 to 0.
- Window emission:
  - If r>=6 && c>=6 at accept, then next cycle out_valid=1, out_row=r-3, out_col=c-3, out_last=(r==IMG_H-1 && c==IMG_W-1).
  - Latency is exactly 1 cycle from accept.
  - If that condition does not hold and the output is free or transferring, out_valid drops to 0.
- Stall: while out_valid && !out_ready, all outputs hold stable, in_ready=0, and no state changes.
- Packing: element A[i][j] occupies out_window[391-8*(7*i+j) -: 8].
  - i=0 is the oldest line; j=0 is the oldest (leftmost) column.
  - Centre pixel is A[3][3]; the newest pixel is A[6][6] at bits [7:0].
- Row crossing: the window contains stale columns for c<6 on every new line. These windows are never emitted.
- in_sof mid-frame: forces (r,c)=(0,0) for that pixel. No window is emitted until r>=6 again. A window already in the output register is still delivered.
- rst mid-frame: an output in flight is dropped; counters return to 0. The next frame must start with in_sof, or is treated as starting at (0,0).
- Counter arithmetic is unsigned. The row/col subtraction of 3 cannot underflow because of the emission condition.

Decomposition:
- Shared package gaussian_pkg holds:
  - BITS and WIDTH;
  - localparam WIN_BITS = WIDTH*WIDTH*BITS (392);
  - an index function giving the bit offset of A[i][j] in the packed word, so both window generator and core use one layout.
- Sub-module line_buffer (parameters DEPTH, BITS):
  - one read and one write at the same address per cycle, read-before-write;
  - enable input tied to accept;
  - instantiated 6 times.

Test Plan (IMG_W=8, IMG_H=8, pixel = 8*r+c unless stated):
- Full frame, no stall, in_sof on the first pixel -> exactly 4 windows.
  - First window one cycle after pixel 54: row=3, col=3, A[0][0]=0, A[3][3]=27, A[6][6]=54.
  - Second window: A[0][0]=1, A[6][6]=55.
  - out_last=1 only on the 4th window, which has A[6][6]=63.
- out_ready held low 5 cycles while the first window is pending -> in_ready=0, window held bit-stable; after release, the sequence is unchanged (4 windows, same values).
- Two back-to-back frames with in_sof -> 8 windows total; second-frame windows contain only second-frame pixels (frame 2 values offset by +64).
- in_sof asserted at pixel 30 of frame 1, then a full 64-pixel frame -> no window before the new r=6,c=6; exactly 4 correct windows afterwards.
- rst pulsed while out_valid=1 mid-frame -> out_valid=0 and out_window=0 next cycle; a following clean frame yields 4 correct windows.
- Constant image 255 through gaussian_window_gen feeding the gaussian core (mask sum 1028) -> core result = (255*1028)>>10 = 255 for every window.
